serial_sub4: RTL

Bit-serial 4-bit subtractor with borrow-in and borrow-out. It is the inverse-operation counterpart of the 4-bit ripple adder: it computes D = A − B − Bin one bit per clock, LSB first, using a start/busy/done handshake. It sits beside the adder in the arithmetic exercise set and trades area for latency. A self-checking bench drives it the same way the adder bench does.

---
 rtl/sub_pkg.sv | 22 ++
 rtl/full_subtractor.sv | 13 +
 rtl/serial_sub4.sv | 107 ++++++++++
 3 files changed

// File: rtl/sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
// Also provides a reference {Bout, D} function for checking results.
package sub_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FIN   = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 4;

    // The extra top bit of the widened difference is the borrow-out.
    function automatic logic [DEF_WIDTH:0] sub_expect(
        input logic [DEF_WIDTH-1:0] a,
        input logic [DEF_WIDTH-1:0] b,
        input logic                 bin
    );
        return {1'b0, a} - {1'b0, b} - {{DEF_WIDTH{1'b0}}, bin};
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = a - b - bi, with borrow-out bo.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bi,
    output logic d,
    output logic bo
);

    assign d  = a ^ b ^ bi;
    assign bo = (~a & b) | (~(a ^ b) & bi);

endmodule

// File: rtl/serial_sub4.sv
// Bit-serial WIDTH-bit subtractor D = A - B - Bin, LSB first, start/busy/done handshake.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow output OVF.
module serial_sub4
    import sub_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             BUSY,
    output logic             DONE,
`ifdef SERIAL_SUB_OVF_EN
    output logic             OVF,
`endif
    output logic [WIDTH-1:0] D,
    output logic             Bout
);

    localparam int            CW   = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-2:0] r_sh;
    logic             br;
    logic [CW-1:0]    count;
    logic             d_bit;
    logic             br_next;
    logic [WIDTH-1:0] r_next;
`ifdef SERIAL_SUB_OVF_EN
    logic             a_msb;
    logic             b_msb;
`endif

    full_subtractor u_fs (
        .a  (a_sh[0]),
        .b  (b_sh[0]),
        .bi (br),
        .d  (d_bit),
        .bo (br_next)
    );

    // Bits collected so far plus the one being produced this cycle.
    assign r_next = {d_bit, r_sh};

    assign BUSY = (state != IDLE);
    assign DONE = (state == FIN);

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            a_sh  <= '0;
            b_sh  <= '0;
            r_sh  <= '0;
            br    <= 1'b0;
            count <= '0;
            D     <= '0;
            Bout  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            OVF   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (START) begin
                        a_sh  <= A;
                        b_sh  <= B;
                        br    <= Bin;
                        r_sh  <= '0;
                        count <= '0;
`ifdef SERIAL_SUB_OVF_EN
                        a_msb <= A[WIDTH-1];
                        b_msb <= B[WIDTH-1];
`endif
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    r_sh  <= r_next[WIDTH-1:1];
                    br    <= br_next;
                    count <= count + CW'(1);
                    if (count == LAST) begin
                        D     <= r_next;
                        Bout  <= br_next;
`ifdef SERIAL_SUB_OVF_EN
                        OVF   <= (a_msb != b_msb) && (d_bit != a_msb);
`endif
                        state <= FIN;
                    end
                end
                FIN:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
